// File: rtl/ramb_pkg.sv
// Shared definitions for the RAMB16BWER byte loader: sizes, state encoding,
// block-RAM port-mapping constants and the load-length clamp.
package ramb_pkg;

  localparam int unsigned ADDR_WIDTH = 11;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  // RAMB16BWER mapping in 9-bit mode: byte address sits at ADDRA[13:3], WEA is 4 bits
  localparam int unsigned ADDR_LSB = 3;
  localparam int unsigned WE_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Lengths beyond the RAM size saturate at DEPTH
  function automatic logic [CNT_WIDTH-1:0] clamp_len(input logic [CNT_WIDTH-1:0] len);
    return (len > CNT_WIDTH'(DEPTH)) ? CNT_WIDTH'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/ramb8_loader_sum.sv
// 8-bit modular accumulator with synchronous clear (priority) and enable.
module ramb8_sum
  import ramb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH-1:0] sum_q;

  // Carries out of bit 7 are dropped by the 8-bit add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q + din_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ramb8_loader.sv
// Streams bytes into one 9-bit-wide RAMB16BWER port, reads the region back and
// compares the readback sum with the write sum.
module ramb8_loader
  import ramb_pkg::*;
(
  input  logic                  CLKIN,
  input  logic                  RESETN,
  input  logic                  START,
  input  logic [CNT_WIDTH-1:0]  LEN,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  input  logic [DATA_WIDTH-1:0] RAM_DO,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS
);

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [CNT_WIDTH-1:0]  wcnt_q;
  logic [CNT_WIDTH-1:0]  rcnt_q;
  logic                  rvld_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;

  logic                  start_ok;
  logic                  wr_acc;
  logic                  rd_issue;
  logic [CNT_WIDTH-1:0]  len_n;
  logic [DATA_WIDTH-1:0] rsum_final;

  assign start_ok   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign wr_acc     = (state_q == ST_WRITE) && DIN_VALID;
  assign rd_issue   = (state_q == ST_VERIFY) && (rcnt_q < n_q);
  assign len_n      = clamp_len(LEN);
  assign rsum_final = rsum + RAM_DO;

  // Write and read sums, both cleared by an accepted START
  ramb8_sum u_wsum (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .clr_i (start_ok),
    .en_i  (wr_acc),
    .din_i (DIN),
    .sum_o (wsum)
  );

  ramb8_sum u_rsum (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .clr_i (start_ok),
    .en_i  (rvld_q && (state_q == ST_VERIFY)),
    .din_i (RAM_DO),
    .sum_o (rsum)
  );

  // RAM port and handshake decode from state; idle value is all zeros
  always_comb begin
    DIN_READY = 1'b0;
    RAM_EN    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_ADDR  = '0;
    RAM_DI    = '0;
    if (state_q == ST_WRITE) begin
      DIN_READY = 1'b1;
      RAM_EN    = DIN_VALID;
      RAM_WE    = DIN_VALID;
      RAM_ADDR  = wcnt_q[ADDR_WIDTH-1:0];
      RAM_DI    = DIN;
    end else if (rd_issue) begin
      RAM_EN    = 1'b1;
      RAM_ADDR  = rcnt_q[ADDR_WIDTH-1:0];
    end
  end

  // Load sequencer: IDLE/DONE -> WRITE -> VERIFY -> DONE
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      rvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            n_q    <= len_n;
            wcnt_q <= '0;
            rcnt_q <= '0;
            rvld_q <= 1'b0;
            if (len_n == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_WRITE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (DIN_VALID) begin
            wcnt_q <= wcnt_q + CNT_WIDTH'(1);
            if (wcnt_q == n_q - CNT_WIDTH'(1)) begin
              state_q <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          rvld_q <= rd_issue;
          if (rd_issue) begin
            rcnt_q <= rcnt_q + CNT_WIDTH'(1);
          end else begin
            // Last read data is on RAM_DO now; fold it in for the compare
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (wsum == rsum_final);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;

endmodule

// File: tb/tb_ramb8_loader.sv
// Self-checking bench for ramb8_loader with a behavioural byte RAM and a
// queue-based expectation of writes, reads and the pass/fail verdict.
module tb_ramb8_loader;
  import ramb_pkg::*;

  logic                  CLKIN = 1'b0;
  logic                  RESETN = 1'b0;
  logic                  START = 1'b0;
  logic [CNT_WIDTH-1:0]  LEN = '0;
  logic [DATA_WIDTH-1:0] DIN = '0;
  logic                  DIN_VALID = 1'b0;
  logic                  DIN_READY;
  logic                  RAM_EN;
  logic                  RAM_WE;
  logic [ADDR_WIDTH-1:0] RAM_ADDR;
  logic [DATA_WIDTH-1:0] RAM_DI;
  logic [DATA_WIDTH-1:0] RAM_DO = '0;
  logic                  BUSY;
  logic                  DONE;
  logic                  PASS;

  ramb8_loader dut (
    .CLKIN     (CLKIN),
    .RESETN    (RESETN),
    .START     (START),
    .LEN       (LEN),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DI    (RAM_DI),
    .RAM_DO    (RAM_DO),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS)
  );

  always #5 CLKIN = ~CLKIN;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte RAM with registered read; optional bit-0 flip on reads of address 1
  logic [7:0] mem [0:DEPTH-1];
  bit corrupt = 1'b0;
  always @(posedge CLKIN) begin
    if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_DI;
      else RAM_DO <= mem[RAM_ADDR] ^ ((corrupt && RAM_ADDR == 1) ? 8'h01 : 8'h00);
    end
  end

  // Observed bus activity, sampled mid-cycle
  int         wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         rd_addr_q[$];
  int         verify_cyc;
  int         we_err;
  int         done_en_err;
  always @(negedge CLKIN) begin
    if (RESETN) begin
      if (RAM_EN && RAM_WE) begin
        wr_addr_q.push_back(int'(RAM_ADDR));
        wr_data_q.push_back(RAM_DI);
      end
      if (RAM_EN && !RAM_WE) rd_addr_q.push_back(int'(RAM_ADDR));
      if (BUSY && !DIN_READY) verify_cyc++;
      if (DIN_READY && (RAM_WE != DIN_VALID || RAM_EN != DIN_VALID)) we_err++;
      if (DONE && RAM_EN) done_en_err++;
    end
  end

  // vmode: 0 valid every cycle, 1 random valid, 2 valid from vpat bits (then 1)
  task automatic run_load(input string tag, input int len, input int vmode,
                          input logic [31:0] vpat, input logic [31:0] fixed,
                          input int nfix, input bit corr, input bit poke);
    int n;
    logic [7:0] bytes[$];
    int idx;
    int cyc;
    int pi;
    int bad;
    bit v;
    bit poked;
    logic [7:0] ws;
    logic [7:0] rs;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    for (int i = 0; i < n; i++) begin
      if (i < nfix) bytes.push_back(fixed[8*i +: 8]);
      else bytes.push_back(8'($urandom));
    end
    corrupt = corr;
    @(posedge CLKIN); #1;
    START = 1'b1;
    LEN = CNT_WIDTH'(len);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    verify_cyc = 0; we_err = 0; done_en_err = 0;
    @(posedge CLKIN); #1;
    START = 1'b0;
    LEN = CNT_WIDTH'($urandom);
    idx = 0; cyc = 0; pi = 0;
    while (idx < n && cyc < 20000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(3) != 0);
        default: v = (pi < 32) ? vpat[pi] : 1'b1;
      endcase
      DIN_VALID = v;
      DIN = v ? bytes[idx] : 8'($urandom);
      @(negedge CLKIN);
      if (DIN_READY && DIN_VALID) idx++;
      pi++; cyc++;
      @(posedge CLKIN); #1;
    end
    DIN_VALID = 1'b0;
    check({tag, "_accepted"}, 32'(idx), 32'(n));
    cyc = 0; poked = 1'b0;
    while (!DONE && cyc < 10000) begin
      if (poke && !poked && BUSY && !DIN_READY) begin
        START = 1'b1; LEN = CNT_WIDTH'(9); poked = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLKIN); #1;
      cyc++;
    end
    START = 1'b0;
    repeat (2) @(posedge CLKIN);
    #1;
    ws = '0; rs = '0;
    for (int i = 0; i < n; i++) begin
      ws = ws + bytes[i];
      rs = rs + ((corr && i == 1) ? (bytes[i] ^ 8'h01) : bytes[i]);
    end
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_pass"}, 32'(PASS), 32'(ws == rs));
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
    check({tag, "_nreads"}, 32'(rd_addr_q.size()), 32'(n));
    bad = 0;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] !== bytes[i]) bad++;
    for (int i = 0; i < n && i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] != i) bad++;
    check({tag, "_addr_data_bad"}, 32'(bad), 32'd0);
    if (n > 0) check({tag, "_last_waddr"}, 32'(wr_addr_q[wr_addr_q.size()-1]), 32'(n - 1));
    check({tag, "_verify_cycles"}, 32'(verify_cyc), (n == 0) ? 32'd0 : 32'(n + 1));
    check({tag, "_we_follows_valid"}, 32'(we_err), 32'd0);
    check({tag, "_no_en_in_done"}, 32'(done_en_err), 32'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge CLKIN);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_pass", 32'(PASS), 32'd0);
    check("rst_ready", 32'(DIN_READY), 32'd0);
    check("rst_en", 32'(RAM_EN), 32'd0);
    RESETN = 1'b1;

    run_load("basic", 4, 0, 32'h0, 32'h04030201, 4, 1'b0, 1'b0);
    run_load("backpressure", 3, 2, 32'h29, 32'h0, 0, 1'b0, 1'b0);
    run_load("corrupt", 2, 0, 32'h0, 32'h000055AA, 2, 1'b1, 1'b0);
    check("corrupt_pass_low", 32'(PASS), 32'd0);
    run_load("empty", 0, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    run_load("start_in_verify", 5, 1, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    run_load("clamp4095", 4095, 1, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++)
      run_load($sformatf("rand%0d", r), $urandom_range(60, 1), 1, 32'h0, 32'h0, 0,
               1'($urandom_range(1)), 1'b0);

    // Reset in the middle of a write burst
    @(posedge CLKIN); #1;
    START = 1'b1; LEN = CNT_WIDTH'(10);
    @(posedge CLKIN); #1;
    START = 1'b0;
    DIN_VALID = 1'b1;
    repeat (5) begin
      DIN = 8'($urandom);
      @(posedge CLKIN); #1;
    end
    #1;
    RESETN = 1'b0;
    #1;
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_done", 32'(DONE), 32'd0);
    check("midrst_pass", 32'(PASS), 32'd0);
    check("midrst_ready", 32'(DIN_READY), 32'd0);
    check("midrst_en", 32'(RAM_EN), 32'd0);
    check("midrst_we", 32'(RAM_WE), 32'd0);
    check("midrst_addr", 32'(RAM_ADDR), 32'd0);
    check("midrst_di", 32'(RAM_DI), 32'd0);
    DIN_VALID = 1'b0;
    @(posedge CLKIN); #1;
    RESETN = 1'b1;
    repeat (3) @(posedge CLKIN);
    #1;
    check("postrst_done", 32'(DONE), 32'd0);
    check("postrst_busy", 32'(BUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
